// File: rtl/fvd_pkg.sv
// Shared types and helpers for the flattened-vector driver: LFSR polynomial,
// state encoding, LFSR step and response-signature fold.
package fvd_pkg;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2,
        DONE   = 2'd3
    } fvd_state_e;

    // Right-shifting Galois step; the tap mask is applied when bit 0 shifts out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

    function automatic logic [31:0] sig_fold(input logic [31:0] sig, input logic [31:0] resp);
        return lfsr_step(sig) ^ resp;
    endfunction

endpackage

// File: rtl/fvd_lfsr32.sv
// Seedable 32-bit Galois LFSR; advances one step per cycle when step_en is high.
// Latency: value reflects a step on the cycle after step_en. No backpressure.
// Reset loads the seed (a zero seed is replaced by 1 so the register cannot lock up).
module fvd_lfsr32
    import fvd_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'h0000_0001,
    parameter int          OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    output logic [OUT_W-1:0] value
);

    localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

    logic [31:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else if (step_en) begin
            state <= lfsr_step(state);
        end
    end

    assign value = state[OUT_W-1:0];

endmodule

// File: rtl/flat_vector_driver.sv
// Drives LFSR vectors onto a DUT wrapper, samples its response after SETTLE_CYCLES
// and streams {index, stimulus, response} records while folding responses into a signature.
// Latency: stimulus-to-capture SETTLE_CYCLES; a stalled res_ready holds the record and stimulus.
// Optional macro FVD_HOLD_CHECK_EN adds the sticky `unstable` output.
module flat_vector_driver
    import fvd_pkg::*;
#(
    parameter int          IN_W          = 24,
    parameter int          OUT_W         = 8,
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] SEED          = 32'h0000_0001,
    localparam int         IDX_W         = $clog2(NUM_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IN_W-1:0]  dut_in_flat,
    input  logic [OUT_W-1:0] dut_out_flat,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_index,
    output logic [IN_W-1:0]  res_in,
    output logic [OUT_W-1:0] res_out,
    output logic [31:0]      signature
`ifdef FVD_HOLD_CHECK_EN
    ,
    output logic             unstable
`endif
);

    localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    if (IN_W < 1 || IN_W > 32 || OUT_W < 1 || OUT_W > 32) begin : g_bad_width
        $error("flat_vector_driver: IN_W and OUT_W must be in 1..32");
    end
    if (NUM_VECTORS < 1 || SETTLE_CYCLES < 1) begin : g_bad_count
        $error("flat_vector_driver: NUM_VECTORS and SETTLE_CYCLES must be >= 1");
    end

    fvd_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [IN_W-1:0]  lfsr_val;
    logic             run_start;
    logic             handshake;
    logic             lfsr_step_en;

    assign run_start    = (state == IDLE || state == DONE) && start;
    assign handshake    = (state == REPORT) && res_ready;
    // The LFSR advances exactly once per vector put on the bus, so a restart
    // from DONE continues the sequence instead of repeating it.
    assign lfsr_step_en = run_start || (handshake && idx != LAST_IDX);

    fvd_lfsr32 #(
        .SEED  (SEED),
        .OUT_W (IN_W)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step_en (lfsr_step_en),
        .value   (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_valid   <= 1'b0;
            dut_in_flat <= '0;
            res_index   <= '0;
            res_in      <= '0;
            res_out     <= '0;
            signature   <= '0;
            idx         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dut_in_flat <= lfsr_val;
                        cnt         <= CNT_INIT;
                        signature   <= '0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        res_out   <= dut_out_flat;
                        res_in    <= dut_in_flat;
                        res_index <= idx;
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        signature <= sig_fold(signature, 32'(res_out));
                        res_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx         <= idx + IDX_W'(1);
                            dut_in_flat <= lfsr_val;
                            cnt         <= CNT_INIT;
                            state       <= SETTLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FVD_HOLD_CHECK_EN
    logic [OUT_W-1:0] prev_out;
    logic             first_settle;

    // The first settle cycle only primes prev_out; later cycles compare against it.
    always_ff @(posedge clk) begin
        if (rst) begin
            unstable     <= 1'b0;
            prev_out     <= '0;
            first_settle <= 1'b1;
        end else begin
            if (run_start) begin
                unstable <= 1'b0;
            end
            if (state == SETTLE) begin
                prev_out     <= dut_out_flat;
                first_settle <= 1'b0;
                if (!first_settle && dut_out_flat != prev_out) begin
                    unstable <= 1'b1;
                end
            end else begin
                first_settle <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_flat_vector_driver.sv
// Directed bench for flat_vector_driver: 4 vectors, 3 settle cycles, identity-style DUT
// (out = in[7:0], optionally with bit 0 toggling every cycle to exercise the hold check).
module tb_flat_vector_driver;

    localparam int IN_W  = 24;
    localparam int OUT_W = 8;
    localparam int NV    = 4;
    localparam int SC    = 3;
    localparam int IDX_W = $clog2(NV + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [IN_W-1:0]  dut_in_flat;
    logic [OUT_W-1:0] dut_out_flat;
    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] res_index;
    logic [IN_W-1:0]  res_in;
    logic [OUT_W-1:0] res_out;
    logic [31:0]      signature;
`ifdef FVD_HOLD_CHECK_EN
    logic             unstable;
`endif

    logic toggle_en = 1'b0;
    logic tog = 1'b0;

    int passes = 0;
    int total  = 0;
    int cyc;
    logic stable;

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    assign dut_out_flat = dut_in_flat[7:0] ^ {7'b0, tog & toggle_en};

    flat_vector_driver #(
        .IN_W          (IN_W),
        .OUT_W         (OUT_W),
        .NUM_VECTORS   (NV),
        .SETTLE_CYCLES (SC),
        .SEED          (32'h0000_0001)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .dut_in_flat  (dut_in_flat),
        .dut_out_flat (dut_out_flat),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_index    (res_index),
        .res_in       (res_in),
        .res_out      (res_out),
        .signature    (signature)
`ifdef FVD_HOLD_CHECK_EN
        ,
        .unstable     (unstable)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge with res_valid low; counts clock edges until a record appears.
    task automatic wait_rec(output int n, output logic stab);
        logic [IN_W-1:0] v0;
        v0   = dut_in_flat;
        n    = 0;
        stab = 1'b1;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
            if (dut_in_flat !== v0) stab = 1'b0;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", res_valid, 0);
        check("rst_din", dut_in_flat, 0);
        check("rst_index", res_index, 0);
        check("rst_res_in", res_in, 0);
        check("rst_res_out", res_out, 0);
        check("rst_sig", signature, 0);
        rst = 1'b0;
        @(negedge clk);

        // Run 1, record 0: latency and stall behaviour
        pulse_start();
        check("r1_din0", dut_in_flat, 32'h000001);
        check("r1_busy", busy, 1);
        wait_rec(cyc, stable);
        check("r1_lat0", cyc, SC);
        check("r1_stable0", stable, 1);
        check("r1_idx0", res_index, 0);
        check("r1_in0", res_in, 32'h000001);
        check("r1_out0", res_out, 32'h01);
        pulse_start();
        repeat (9) @(negedge clk);
        check("stall_valid", res_valid, 1);
        check("stall_in", res_in, 32'h000001);
        check("stall_idx", res_index, 0);
        check("stall_din", dut_in_flat, 32'h000001);
        check("stall_sig", signature, 0);
        handshake();
        check("hs0_valid", res_valid, 0);
        check("hs0_sig", signature, 32'h0000_0001);

        wait_rec(cyc, stable);
        check("r1_lat1", cyc, SC);
        check("r1_stable1", stable, 1);
        check("r1_idx1", res_index, 1);
        check("r1_in1", res_in, 32'h200003);
        check("r1_out1", res_out, 32'h03);
        handshake();
        check("hs1_sig", signature, 32'h8020_0000);

        wait_rec(cyc, stable);
        check("r1_in2", res_in, 32'h300002);
        check("r1_idx2", res_index, 2);
        handshake();
        check("hs2_sig", signature, 32'h4010_0002);

        wait_rec(cyc, stable);
        check("r1_in3", res_in, 32'h180001);
        check("r1_idx3", res_index, 3);
        handshake();
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_sig", signature, 32'h2008_0000);
        repeat (3) @(negedge clk);
        check("frozen_din", dut_in_flat, 32'h180001);
        check("frozen_done", done, 1);
        check("frozen_sig", signature, 32'h2008_0000);

        // Run 2 from DONE continues the LFSR sequence
        pulse_start();
        check("r2_done", done, 0);
        check("r2_busy", busy, 1);
        check("r2_din0", dut_in_flat, 32'h2C0003);
        check("r2_sig", signature, 0);
        wait_rec(cyc, stable);
        check("r2_in0", res_in, 32'h2C0003);
        check("r2_idx0", res_index, 0);
        handshake();
        wait_rec(cyc, stable);
        check("r2_in1", res_in, 32'h360002);
        check("r2_idx1", res_index, 1);

        // Reset in REPORT, with start held in the same cycle
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        check("abort_din", dut_in_flat, 0);
        check("abort_res_in", res_in, 0);
        check("abort_index", res_index, 0);
        check("abort_sig", signature, 0);
        @(negedge clk);
        check("abort_idle", busy, 0);

        // Reseeded run reproduces record 0
        pulse_start();
        wait_rec(cyc, stable);
        check("r3_in0", res_in, 32'h000001);
        check("r3_idx0", res_index, 0);
`ifdef FVD_HOLD_CHECK_EN
        check("hold_clean", unstable, 0);
        handshake();
        toggle_en = 1'b1;
        wait_rec(cyc, stable);
        toggle_en = 1'b0;
        check("hold_set", unstable, 1);
        handshake();
        wait_rec(cyc, stable);
        check("hold_sticky", unstable, 1);
`endif
        handshake();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
